// File: rtl/seg7_pkg.sv
// Shared 7-segment display definitions: segment patterns, active-low digit selects, frame FSM states.
package seg7_pkg;

   // Segment order {a,b,c,d,e,f,g,dp}, active-high; dp is always clear in the digit glyphs
   localparam logic [7:0] SEG_0 = 8'hFC;
   localparam logic [7:0] SEG_1 = 8'h60;
   localparam logic [7:0] SEG_2 = 8'hDA;
   localparam logic [7:0] SEG_3 = 8'hF2;
   localparam logic [7:0] SEG_4 = 8'h66;
   localparam logic [7:0] SEG_5 = 8'hB6;
   localparam logic [7:0] SEG_6 = 8'hBE;
   localparam logic [7:0] SEG_7 = 8'hE0;
   localparam logic [7:0] SEG_8 = 8'hFE;
   localparam logic [7:0] SEG_9 = 8'hF6;
   localparam logic [7:0] SEG_A = 8'hEE;
   localparam logic [7:0] SEG_B = 8'h3E;
   localparam logic [7:0] SEG_C = 8'h1A;
   localparam logic [7:0] SEG_D = 8'h7A;
   localparam logic [7:0] SEG_E = 8'h9E;
   localparam logic [7:0] SEG_F = 8'h8E;

   localparam logic [3:0] SEL_D3    = 4'b0111;
   localparam logic [3:0] SEL_D2    = 4'b1011;
   localparam logic [3:0] SEL_D1    = 4'b1101;
   localparam logic [3:0] SEL_D0    = 4'b1110;
   localparam logic [3:0] SEL_BLANK = 4'b1111;

   typedef enum logic [1:0] {
      WAIT_D3 = 2'd0,
      WAIT_D2 = 2'd1,
      WAIT_D1 = 2'd2,
      WAIT_D0 = 2'd3
   } frame_state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Inverse 7-segment lookup: segments a..g back to a hex nibble; hit=0 for any non-glyph pattern.
module seg7_to_hex
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic       hit,
   output logic [3:0] nibble
);

   always_comb begin
      hit    = 1'b1;
      nibble = 4'h0;
      case (seg)
         SEG_0[7:1]: nibble = 4'h0;
         SEG_1[7:1]: nibble = 4'h1;
         SEG_2[7:1]: nibble = 4'h2;
         SEG_3[7:1]: nibble = 4'h3;
         SEG_4[7:1]: nibble = 4'h4;
         SEG_5[7:1]: nibble = 4'h5;
         SEG_6[7:1]: nibble = 4'h6;
         SEG_7[7:1]: nibble = 4'h7;
         SEG_8[7:1]: nibble = 4'h8;
         SEG_9[7:1]: nibble = 4'h9;
         SEG_A[7:1]: nibble = 4'hA;
         SEG_B[7:1]: nibble = 4'hB;
         SEG_C[7:1]: nibble = 4'hC;
         SEG_D[7:1]: nibble = 4'hD;
         SEG_E[7:1]: nibble = 4'hE;
         SEG_F[7:1]: nibble = 4'hF;
         default:    hit    = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_capture.sv
// Display-bus monitor: debounces the scanned LED/selector pair and reassembles the 16-bit shown value.
// Optional `SEGCAP_DP_CHECK_EN: a lit decimal point on an accepted digit is reported as a frame error.
module seg_scan_capture
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 8
) (
   input  logic        selector_clock,
   input  logic        reset,
   input  logic [7:0]  LED,
   input  logic [3:0]  selector,
   output logic [15:0] num,
   output logic        num_valid,
   output logic        frame_err
);

   localparam int                CNT_W   = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ARM = CNT_W'(STABLE_CYCLES - 2);

   logic [7:0]       led_in;
   logic             dp_bad;
   logic [7:0]       s_led, p_led;
   logic [3:0]       s_sel, p_sel;
   logic [11:0]      last_acc;
   logic [CNT_W-1:0] stab_cnt;
   logic             same, accept, legal_sel;
   logic             dec_hit;
   logic [3:0]       dec_nib;
   logic [3:0]       d3_nib, d2_nib, d1_nib;
   frame_state_t     state, nxt_state;
   logic             st_d3, st_d2, st_d1, ld_num, err;

`ifdef SEGCAP_DP_CHECK_EN
   assign led_in = LED;
   assign dp_bad = s_led[0];
`else
   assign led_in = {LED[7:1], 1'b0};
   assign dp_bad = 1'b0;
`endif

   // Sample stage: current and previous registered bus samples
   always_ff @(posedge selector_clock) begin
      if (reset) begin
         s_led <= '0;
         s_sel <= '0;
         p_led <= '0;
         p_sel <= '0;
      end else begin
         s_led <= led_in;
         s_sel <= selector;
         p_led <= s_led;
         p_sel <= s_sel;
      end
   end

   assign same = ({s_led, s_sel} == {p_led, p_sel});

   always_ff @(posedge selector_clock) begin
      if (reset)
         stab_cnt <= '0;
      else if (!same)
         stab_cnt <= '0;
      else if (stab_cnt != CNT_MAX)
         stab_cnt <= stab_cnt + 1'b1;
   end

   // A short glitch restarts the count; re-settling on the pattern just accepted is the same dwell
   assign accept    = same && (stab_cnt == CNT_ARM) && ({s_led, s_sel} != last_acc);
   assign legal_sel = (s_sel == SEL_D3) || (s_sel == SEL_D2) ||
                      (s_sel == SEL_D1) || (s_sel == SEL_D0);

   seg7_to_hex u_dec (
      .seg    (s_led[7:1]),
      .hit    (dec_hit),
      .nibble (dec_nib)
   );

   always_comb begin
      nxt_state = state;
      st_d3     = 1'b0;
      st_d2     = 1'b0;
      st_d1     = 1'b0;
      ld_num    = 1'b0;
      err       = 1'b0;
      if (accept && (s_sel != SEL_BLANK)) begin
         if (!legal_sel || !dec_hit || dp_bad) begin
            err       = 1'b1;
            nxt_state = WAIT_D3;
         end else if (s_sel == SEL_D3) begin
            st_d3     = 1'b1;
            nxt_state = WAIT_D2;
         end else begin
            case (state)
               WAIT_D3: nxt_state = WAIT_D3;
               WAIT_D2: if (s_sel == SEL_D2) begin
                           st_d2     = 1'b1;
                           nxt_state = WAIT_D1;
                        end else begin
                           err       = 1'b1;
                           nxt_state = WAIT_D3;
                        end
               WAIT_D1: if (s_sel == SEL_D1) begin
                           st_d1     = 1'b1;
                           nxt_state = WAIT_D0;
                        end else begin
                           err       = 1'b1;
                           nxt_state = WAIT_D3;
                        end
               WAIT_D0: begin
                           if (s_sel == SEL_D0) ld_num = 1'b1;
                           else                 err    = 1'b1;
                           nxt_state = WAIT_D3;
                        end
               default: nxt_state = WAIT_D3;
            endcase
         end
      end
   end

   // Frame stage: state, nibble slots and output registers
   always_ff @(posedge selector_clock) begin
      if (reset) begin
         state     <= WAIT_D3;
         d3_nib    <= '0;
         d2_nib    <= '0;
         d1_nib    <= '0;
         num       <= '0;
         num_valid <= 1'b0;
         frame_err <= 1'b0;
         last_acc  <= '0;
      end else begin
         state     <= nxt_state;
         num_valid <= ld_num;
         frame_err <= err;
         if (st_d3)  d3_nib <= dec_nib;
         if (st_d2)  d2_nib <= dec_nib;
         if (st_d1)  d1_nib <= dec_nib;
         if (ld_num) num    <= {d3_nib, d2_nib, d1_nib, dec_nib};
         if (accept && (s_sel != SEL_BLANK)) last_acc <= {s_led, s_sel};
      end
   end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: frames are scanned like the display driver, events checked on output.
module tb_seg_scan_capture;

   logic        selector_clock = 1'b0;
   logic        reset;
   logic [7:0]  LED;
   logic [3:0]  selector;
   logic [15:0] num;
   logic        num_valid;
   logic        frame_err;

   typedef struct {
      bit          is_err;
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;
   logic prev_nv  = 1'b0;

   seg_scan_capture #(.STABLE_CYCLES(8)) dut (
      .selector_clock (selector_clock),
      .reset          (reset),
      .LED            (LED),
      .selector       (selector),
      .num            (num),
      .num_valid      (num_valid),
      .frame_err      (frame_err)
   );

   always #5 selector_clock = ~selector_clock;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] enc(input logic [3:0] n);
      case (n)
         4'h0: enc = 8'hFC;  4'h1: enc = 8'h60;  4'h2: enc = 8'hDA;  4'h3: enc = 8'hF2;
         4'h4: enc = 8'h66;  4'h5: enc = 8'hB6;  4'h6: enc = 8'hBE;  4'h7: enc = 8'hE0;
         4'h8: enc = 8'hFE;  4'h9: enc = 8'hF6;  4'hA: enc = 8'hEE;  4'hB: enc = 8'h3E;
         4'hC: enc = 8'h1A;  4'hD: enc = 8'h7A;  4'hE: enc = 8'h9E;  default: enc = 8'h8E;
      endcase
   endfunction

   function automatic logic [3:0] sel_of(input int d);
      case (d)
         3:       sel_of = 4'b0111;
         2:       sel_of = 4'b1011;
         1:       sel_of = 4'b1101;
         default: sel_of = 4'b1110;
      endcase
   endfunction

   task automatic dwell(input logic [7:0] led, input logic [3:0] sel, input int cycles);
      LED      = led;
      selector = sel;
      repeat (cycles) @(posedge selector_clock);
      #1;
   endtask

   task automatic scan(input logic [15:0] v);
      for (int d = 3; d >= 0; d--) begin
         dwell(enc(v[d*4 +: 4]), sel_of(d), 100);
         dwell(8'h00, 4'b1111, 2);
      end
   endtask

   task automatic push_val(input logic [15:0] v);
      exp_t e;
      e.is_err = 1'b0;
      e.val    = v;
      sb.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e.is_err = 1'b1;
      e.val    = 16'h0000;
      sb.push_back(e);
   endtask

   always @(negedge selector_clock) begin
      if (!reset && (num_valid || frame_err)) begin
         exp_t e;
         check("excl", {31'd0, num_valid & frame_err}, 32'd0);
         if (num_valid) check("nv_single", {31'd0, prev_nv}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_event", {30'd0, num_valid, frame_err}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("event_kind", {31'd0, frame_err}, {31'd0, e.is_err});
            if (!e.is_err) check("num", {16'd0, num}, {16'd0, e.val});
         end
      end
      prev_nv = num_valid;
   end

   initial begin
      reset    = 1'b1;
      LED      = 8'h00;
      selector = 4'b1111;
      repeat (3) @(posedge selector_clock);
      #1;
      check("rst_num", {16'd0, num}, 32'd0);
      check("rst_nv", {31'd0, num_valid}, 32'd0);
      check("rst_fe", {31'd0, frame_err}, 32'd0);
      reset = 1'b0;
      dwell(8'h00, 4'b1111, 5);

      // Plain frame
      push_val(16'h1A2F);
      scan(16'h1A2F);

      // Short glitch inside the D2 dwell
      push_val(16'h1A2F);
      dwell(enc(4'h1), sel_of(3), 100);
      dwell(8'hEE, sel_of(2), 40);
      dwell(8'h60, sel_of(2), 3);
      dwell(8'hEE, sel_of(2), 57);
      dwell(enc(4'h2), sel_of(1), 100);
      dwell(enc(4'hF), sel_of(0), 100);
      dwell(8'h00, 4'b1111, 20);
      check("glitch_num", {16'd0, num}, 32'h1A2F);

      // Non-glyph on D1 breaks the frame; D0 afterwards is only hunted past
      push_err();
      dwell(enc(4'h0), sel_of(3), 100);
      dwell(enc(4'h0), sel_of(2), 100);
      dwell(8'h00, sel_of(1), 100);
      dwell(enc(4'h0), sel_of(0), 100);
      check("err_keeps_num", {16'd0, num}, 32'h1A2F);
      push_val(16'h0042);
      scan(16'h0042);

      // Start mid-frame at D1
      dwell(enc(4'h3), sel_of(1), 100);
      dwell(enc(4'h4), sel_of(0), 100);
      push_val(16'hBEEF);
      scan(16'hBEEF);

      // Reset while waiting for D1
      dwell(enc(4'h5), sel_of(3), 100);
      dwell(enc(4'h6), sel_of(2), 100);
      LED      = enc(4'h7);
      selector = sel_of(1);
      reset    = 1'b1;
      repeat (3) @(posedge selector_clock);
      #1;
      check("midrst_num", {16'd0, num}, 32'd0);
      check("midrst_nv", {31'd0, num_valid}, 32'd0);
      reset = 1'b0;
      dwell(enc(4'h7), sel_of(1), 100);
      dwell(enc(4'h8), sel_of(0), 100);
      check("after_rst_num", {16'd0, num}, 32'd0);
      push_val(16'h1234);
      scan(16'h1234);

      // Decimal point lit on every digit
`ifdef SEGCAP_DP_CHECK_EN
      for (int k = 0; k < 4; k++) push_err();
`else
      push_val(16'h0000);
`endif
      for (int d = 3; d >= 0; d--) begin
         dwell(8'hFD, sel_of(d), 100);
         dwell(8'h00, 4'b1111, 2);
      end

      dwell(8'h00, 4'b1111, 30);
      check("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
